// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RV32I-subset control path: ALU ops, controller
// states, opcodes and datapath mux selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_FAULT     = 4'd11
  } ctrl_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {SRC_A_PC = 2'd0, SRC_A_RS1 = 2'd1, SRC_A_OLD_PC = 2'd2} alu_src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2} alu_src_b_t;
  typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3} imm_sel_t;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_t;

  // States that hold mem_req and are therefore guarded by the timeout counter.
  function automatic logic is_wait_state(ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7_5; flags encodings the
// datapath does not implement (SLTU-slot 011 and arithmetic right shift).
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output alu_op_t    alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct3)
      3'b000:  alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b001:  alu_op = ALU_SLL;
      3'b101: begin
        alu_op  = ALU_SRL;
        illegal = funct7_5;
      end
      3'b010:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM driving the shared datapath strobes and mux selects.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt / instret performance counters.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] imm_sel,
  output logic [1:0] result_src,
  output logic       fault,
  output logic [3:0] state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  alu_op_t dec_op;
  logic dec_illegal, wait_miss, timeout;

  alu_decoder u_alu_decoder (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_rtype (opcode == OP_R),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  assign wait_miss = is_wait_state(state_q) && !mem_ready;
  assign timeout   = wait_miss && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_FAULT;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default:            state_d = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = dec_illegal ? S_FAULT : S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB; else if (timeout) state_d = S_FAULT;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_FAULT;
      S_BRANCH:    state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_FAULT;
      S_JAL:       state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  // Counter restarts on every state change so each wait state gets a full budget.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) tmo_d = '0;
    else if (wait_miss)     tmo_d = tmo_q + 1'b1;
  end

  // Outputs are gated by rst so an async reset drops mem_req immediately.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    imm_sel    = IMM_I;
    result_src = RES_ALU;
    fault      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_sel   = IMM_B;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = dec_op;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = dec_op;
        end
        S_ALU_WB: reg_write = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEM_READ: mem_req = 1'b1;
        S_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_SUB;
          pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        end
        S_JAL: begin
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          result_src = RES_PC4;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

  assign state_o = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; expectations go through a scoreboard queue.
// Honours CTRL_PERF_CNT_EN when the design is built with it.
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst, funct7_5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_we, ir_write, pc_write, reg_write, fault;
  logic [1:0] alu_src_a, alu_src_b, imm_sel, result_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .result_src(result_src), .fault(fault), .state_o(state_o)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
  );

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] REQ  = 6'b100000;
  localparam logic [5:0] WE   = 6'b010000;
  localparam logic [5:0] IRW  = 6'b001000;
  localparam logic [5:0] PCW  = 6'b000100;
  localparam logic [5:0] RGW  = 6'b000010;
  localparam logic [5:0] FLT  = 6'b000001;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [5:0] strb();
    return {mem_req, mem_we, ir_write, pc_write, reg_write, fault};
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_chk(obs);
  endtask

  // Checks the state and the strobe vector of the current cycle.
  task automatic cyc(input string tag, input ctrl_state_t s, input logic [5:0] st);
    #1;
    push_exp({tag, ".state"}, 32'(s));
    push_exp({tag, ".strb"}, 32'(st));
    pop_chk(32'(state_o));
    pop_chk(32'(strb()));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ir(input logic [31:0] ir);
    opcode   = ir[6:0];
    funct3   = ir[14:12];
    funct7_5 = ir[30];
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_n;
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    set_ir(32'h0);
    #3;
    chk("rst.state", 32'(state_o), 32'(S_FETCH));
    chk("rst.strb", 32'(strb()), 32'(NONE));

    // add x7,x6,x5 with zero-wait memory
    do_reset();
    set_ir(32'h005303b3);
    mem_ready = 1'b1;
    cyc("t1.c1", S_FETCH, REQ | IRW | PCW);
    chk("t1.c1.srcb", 32'(alu_src_b), 32'(SRC_B_FOUR));
    chk("t1.c1.aluop", 32'(alu_op), 32'(ALU_ADD));
    tick(); cyc("t1.c2", S_DECODE, NONE);
    chk("t1.c2.srca", 32'(alu_src_a), 32'(SRC_A_OLD_PC));
    chk("t1.c2.imm", 32'(imm_sel), 32'(IMM_B));
    tick(); cyc("t1.c3", S_EXEC_R, NONE);
    chk("t1.c3.aluop", 32'(alu_op), 32'(ALU_ADD));
    chk("t1.c3.srca", 32'(alu_src_a), 32'(SRC_A_RS1));
    tick(); cyc("t1.c4", S_ALU_WB, RGW);
    chk("t1.c4.res", 32'(result_src), 32'(RES_ALU));
    tick(); cyc("t1.c5", S_FETCH, REQ | IRW | PCW);
`ifdef CTRL_PERF_CNT_EN
    chk("t1.instret", instret, 32'd1);
    chk("t1.cycle_cnt", cycle_cnt, 32'd4);
`endif

    // sub, then illegal R-type funct3=011
    set_ir(32'h405303b3);
    tick(); tick(); cyc("t2.sub", S_EXEC_R, NONE);
    chk("t2.sub.aluop", 32'(alu_op), 32'(ALU_SUB));
    tick(); cyc("t2.sub.wb", S_ALU_WB, RGW);
    tick(); cyc("t2.sub.fetch", S_FETCH, REQ | IRW | PCW);
    set_ir(32'h005333b3);
    tick(); cyc("t2.ill.dec", S_DECODE, NONE);
    tick(); cyc("t2.ill.exec", S_EXEC_R, NONE);
    tick(); cyc("t2.ill.fault", S_FAULT, FLT);
    tick(); cyc("t2.ill.sticky", S_FAULT, FLT);

    // lw with ready delayed 3 cycles in MEM_READ
    do_reset();
    set_ir(32'h0002a383);
    mem_ready = 1'b1;
    cyc("t3.c1", S_FETCH, REQ | IRW | PCW);
    tick(); cyc("t3.c2", S_DECODE, NONE);
    tick(); cyc("t3.c3", S_MEM_ADDR, NONE);
    chk("t3.c3.imm", 32'(imm_sel), 32'(IMM_I));
    mem_ready = 1'b0;
    tick();
    req_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (state_o != S_MEM_READ) break;
      if (mem_req) req_n++;
      tick();
    end
    chk("t3.req_cycles", 32'(req_n), 32'd4);
    cyc("t3.wb", S_MEM_WB, RGW);
    chk("t3.wb.res", 32'(result_src), 32'(RES_MEM));
    tick(); cyc("t3.fetch", S_FETCH, REQ | IRW | PCW);

    // sw, zero-wait
    set_ir(32'h0072a023);
    tick(); tick(); cyc("t3.sw.addr", S_MEM_ADDR, NONE);
    chk("t3.sw.imm", 32'(imm_sel), 32'(IMM_S));
    tick(); cyc("t3.sw.write", S_MEM_WRITE, REQ | WE);
    tick(); cyc("t3.sw.fetch", S_FETCH, REQ | IRW | PCW);

    // beq taken / not taken, bne taken, jal
    set_ir(32'h00628463);
    zero = 1'b1;
    tick(); tick(); cyc("t4.beq1", S_BRANCH, PCW);
    chk("t4.beq1.aluop", 32'(alu_op), 32'(ALU_SUB));
    tick(); cyc("t4.beq1.fetch", S_FETCH, REQ | IRW | PCW);
    zero = 1'b0;
    tick(); tick(); cyc("t4.beq0", S_BRANCH, NONE);
    tick(); cyc("t4.beq0.fetch", S_FETCH, REQ | IRW | PCW);
    set_ir(32'h00629463);
    tick(); tick(); cyc("t4.bne", S_BRANCH, PCW);
    tick(); cyc("t4.bne.fetch", S_FETCH, REQ | IRW | PCW);
    set_ir(32'h008000ef);
    tick(); tick(); cyc("t4.jal", S_JAL, PCW | RGW);
    chk("t4.jal.res", 32'(result_src), 32'(RES_PC4));
    tick(); cyc("t4.jal.fetch", S_FETCH, REQ | IRW | PCW);

    // addi, xori, then srai (unsupported)
    set_ir(32'h00500093);
    tick(); tick(); cyc("t4.addi", S_EXEC_I, NONE);
    chk("t4.addi.srcb", 32'(alu_src_b), 32'(SRC_B_IMM));
    chk("t4.addi.aluop", 32'(alu_op), 32'(ALU_ADD));
    tick(); cyc("t4.addi.wb", S_ALU_WB, RGW);
    tick();
    set_ir(32'h0010c093);
    tick(); tick(); #1;
    chk("t4.xori.aluop", 32'(alu_op), 32'(ALU_XOR));
    tick(); tick(); cyc("t4.xori.fetch", S_FETCH, REQ | IRW | PCW);
`ifdef CTRL_PERF_CNT_EN
    chk("t4.instret", instret, 32'd8);
`endif
    set_ir(32'h4010d093);
    tick(); tick(); cyc("t4.srai", S_EXEC_I, NONE);
    tick(); cyc("t4.srai.fault", S_FAULT, FLT);

    // fetch timeout, then reset during MEM_READ
    do_reset();
    req_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fault) break;
      if (mem_req) req_n++;
      tick();
    end
    chk("t5.tmo_req_cycles", 32'(req_n), 32'd16);
    cyc("t5.tmo", S_FAULT, FLT);
    mem_ready = 1'b1;
    tick(); tick(); cyc("t5.tmo.sticky", S_FAULT, FLT);

    do_reset();
    set_ir(32'h0002a383);
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); cyc("t5.mr", S_MEM_READ, REQ);
    tick();
    rst = 1'b1;
    #1;
    chk("t5.rst.req", 32'(mem_req), 32'd0);
    chk("t5.rst.state", 32'(state_o), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    #2;
    cyc("t5.rel", S_FETCH, REQ);

    // all-zero instruction word
    do_reset();
    set_ir(32'h00000000);
    mem_ready = 1'b1;
    cyc("t6.c1", S_FETCH, REQ | IRW | PCW);
    tick(); cyc("t6.c2", S_DECODE, NONE);
    tick(); cyc("t6.c3", S_FAULT, FLT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
